// File: rtl/rr_mux_arb.sv
// rr_mux_arb: registered N-to-1 valid/ready channel mux with round-robin or fixed-priority grant
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_data         N words of W bits, channel i at [i*W +: W]
//   in_valid        per-channel request
//   in_ready        per-channel accept, combinational, one-hot or zero
//   out_data        registered selected word
//   out_chan        registered source channel index of out_data
//   out_valid       out_data/out_chan hold a word
//   out_ready       consumer accept
module rr_mux_arb #(
    parameter int N = 4,
    parameter int W = 4,
    parameter int MODE = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N*W-1:0]                  in_data,
    input  logic [N-1:0]                    in_valid,
    output logic [N-1:0]                    in_ready,
    output logic [W-1:0]                    out_data,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] out_chan,
    output logic                            out_valid,
    input  logic                            out_ready
);
    localparam int CW = N > 1 ? $clog2(N) : 1;
    logic [CW-1:0] last;
    logic [CW-1:0] gnt;
    logic          found;
    logic          grant;
    int            idx;
    // Scan starts one past the last winner in round-robin mode, at 0 in fixed-priority mode.
    always_comb begin
        found = 1'b0;
        gnt = '0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (MODE == 0) ? int'(last) + 1 + k : k;
            idx = (idx >= N) ? idx - N : idx;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                gnt = CW'(idx);
            end
        end
    end
    // Gated by rst so no producer sees an accept while the output register is held in reset.
    assign grant = !rst && (!out_valid || out_ready) && found;
    assign in_ready = grant ? N'(1) << gnt : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_chan <= '0;
            last <= CW'(N - 1);
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data <= in_data[int'(gnt)*W +: W];
            out_chan <= gnt;
            if (MODE == 0) last <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: table-driven and scoreboard bench for rr_mux_arb in both grant modes
module tb_rr_mux_arb;
    typedef struct {
        int         m;
        logic [3:0] v;
        logic       r;
        logic [3:0] er;
        logic       eo;
    } vec_t;
    logic        clk = 0;
    logic        rst = 0;
    logic [15:0] in_data = 16'hC953;
    logic [3:0]  in_valid = '0;
    logic        out_ready = 1'b1;
    logic [3:0]  rdy [2];
    logic [3:0]  od [2];
    logic [1:0]  oc [2];
    logic        ov [2];
    logic [5:0]  q0 [$];
    logic [5:0]  q1 [$];
    vec_t        vt [27];
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    rr_mux_arb #(.N(4), .W(4), .MODE(0)) d0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
        .out_data(od[0]), .out_chan(oc[0]), .out_valid(ov[0]), .out_ready(out_ready)
    );
    rr_mux_arb #(.N(4), .W(4), .MODE(1)) d1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
        .out_data(od[1]), .out_chan(oc[1]), .out_valid(ov[1]), .out_ready(out_ready)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
        end
    endtask
    task automatic step(input int m, input logic [3:0] v, input logic r, input logic [3:0] er,
                        input logic eo, input string nm);
        logic [5:0] e;
        logic [1:0] c;
        @(negedge clk);
        in_valid = v;
        out_ready = r;
        #1;
        chk({nm, ".in_ready"}, 32'(rdy[m]), 32'(er));
        chk({nm, ".out_valid"}, 32'(ov[m]), 32'(eo));
        if (ov[m] && r) begin
            if ((m == 0 ? q0.size() : q1.size()) == 0) begin
                chk({nm, ".unexpected_xfer"}, {oc[m], od[m]}, 32'hFFFF);
            end else begin
                e = (m == 0) ? q0.pop_front() : q1.pop_front();
                chk({nm, ".xfer"}, 32'({oc[m], od[m]}), 32'(e));
            end
        end
        if (er != 0) begin
            c = 0;
            for (int i = 0; i < 4; i++) if (er[i]) c = 2'(i);
            e = {c, in_data[int'(c)*4 +: 4]};
            if (m == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        in_valid = 4'b1111;
        #2 rst = 1;
        #1;
        chk("rst.in_ready0", 32'(rdy[0]), 0);
        chk("rst.in_ready1", 32'(rdy[1]), 0);
        chk("rst.out0", {ov[0], oc[0], od[0]}, 0);
        chk("rst.out1", {ov[1], oc[1], od[1]}, 0);
        in_valid = '0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 0;
    endtask
    initial begin
        vt[0]  = '{0, 4'b1111, 1'b1, 4'b0001, 1'b0};
        vt[1]  = '{0, 4'b1111, 1'b1, 4'b0010, 1'b1};
        vt[2]  = '{0, 4'b1111, 1'b1, 4'b0100, 1'b1};
        vt[3]  = '{0, 4'b1111, 1'b1, 4'b1000, 1'b1};
        vt[4]  = '{0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        vt[5]  = '{0, 4'b1111, 1'b1, 4'b0010, 1'b1};
        vt[6]  = '{0, 4'b1111, 1'b1, 4'b0100, 1'b1};
        vt[7]  = '{0, 4'b1111, 1'b0, 4'b0000, 1'b1};
        vt[8]  = '{0, 4'b1111, 1'b0, 4'b0000, 1'b1};
        vt[9]  = '{0, 4'b1111, 1'b0, 4'b0000, 1'b1};
        vt[10] = '{0, 4'b1111, 1'b1, 4'b1000, 1'b1};
        vt[11] = '{0, 4'b0100, 1'b1, 4'b0100, 1'b1};
        vt[12] = '{0, 4'b0101, 1'b1, 4'b0001, 1'b1};
        vt[13] = '{0, 4'b0101, 1'b1, 4'b0100, 1'b1};
        vt[14] = '{0, 4'b0000, 1'b1, 4'b0000, 1'b1};
        vt[15] = '{0, 4'b0000, 1'b1, 4'b0000, 1'b0};
        vt[16] = '{0, 4'b1000, 1'b1, 4'b1000, 1'b0};
        vt[17] = '{0, 4'b1000, 1'b1, 4'b1000, 1'b1};
        vt[18] = '{0, 4'b0000, 1'b1, 4'b0000, 1'b1};
        vt[19] = '{0, 4'b0000, 1'b1, 4'b0000, 1'b0};
        vt[20] = '{1, 4'b1110, 1'b1, 4'b0010, 1'b0};
        vt[21] = '{1, 4'b1110, 1'b1, 4'b0010, 1'b1};
        vt[22] = '{1, 4'b1110, 1'b1, 4'b0010, 1'b1};
        vt[23] = '{1, 4'b1100, 1'b1, 4'b0100, 1'b1};
        vt[24] = '{1, 4'b1111, 1'b1, 4'b0001, 1'b1};
        vt[25] = '{1, 4'b0000, 1'b1, 4'b0000, 1'b1};
        vt[26] = '{1, 4'b0000, 1'b1, 4'b0000, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "idle");
            chk("idle.out", {oc[0], od[0]}, 0);
        end
        for (int i = 0; i < 20; i++) step(vt[i].m, vt[i].v, vt[i].r, vt[i].er, vt[i].eo, $sformatf("rr%0d", i));
        step(0, 4'b0010, 1'b1, 4'b0010, 1'b0, "mid.load");
        step(0, 4'b1111, 1'b0, 4'b0000, 1'b1, "mid.stall");
        chk("mid.held", {oc[0], od[0]}, 32'h15);
        #2 rst = 1;
        in_valid = '0;
        #1;
        chk("mid.async_valid", 32'(ov[0]), 0);
        chk("mid.async_ready", 32'(rdy[0]), 0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 0;
        step(0, 4'b1111, 1'b1, 4'b0001, 1'b0, "mid.first");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b1, "mid.drain");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "mid.empty");
        do_reset();
        for (int i = 20; i < 27; i++) step(vt[i].m, vt[i].v, vt[i].r, vt[i].er, vt[i].eo, $sformatf("fp%0d", i));
        chk("q0.left", 32'(q0.size()), 0);
        chk("q1.left", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised, registered N-to-1 channel multiplexer with valid/ready handshakes on every input and on the output.
- Generalises the 2-to-1 select mux in four ways: N channels, W-bit data, an internal selection policy (round-robin or fixed priority) in place of an external select, and one output register stage.
- Sits between multiple ALU result producers and a single consumer (writeback/result bus).

Parameters:
- N, 4: number of input channels; 2..16.
- W, 4: data width per channel in bits.
- MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept; combinational; at most one bit high.
- out_data  output  W  registered selected word.
- out_chan  output  clog2(N) (min 1)  registered index of the source channel of out_data.
- out_valid  output  1  registered; out_data/out_chan valid.
- out_ready  input  1  consumer accepts when high with out_valid.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high; ports named clk and rst.
- Reset (async assert, any cycle, mid-transfer included):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=N-1, so channel 0 has first priority.
  - Any word held in the output register is discarded.
  - While rst is high, in_ready=0.
- Output slot:
  - slot_free = !out_valid || out_ready.
  - A transfer completes on a clock edge when out_valid && out_ready.
- Grant (combinational, evaluated every cycle):
  - If slot_free and any in_valid, exactly one channel g is granted and in_ready[g]=1.
  - Otherwise in_ready is all zeros.
  - in_ready never depends on in_data.
- MODE 0 grant: first i with in_valid[i], scanning (last+1) mod N upward with wrap-around.
- MODE 1 grant: lowest index i with in_valid[i]; the pointer is ignored.
- On an edge with a grant:
  - out_data <= in_data[g]; out_chan <= g; out_valid <= 1.
  - MODE 0 only: last <= g.
- On an edge with no grant while out_valid && out_ready: out_valid <= 0. out_data and out_chan hold their last values.
- With out_valid && !out_ready (stall): out_data, out_chan and out_valid hold; in_ready=0.
- Throughput and latency:
  - Full throughput of 1 word/cycle when out_ready stays high (accept and drain in the same edge).
  - Latency is 1 cycle from the in_valid&&in_ready edge to out_valid.
- Fairness (MODE 0): with all N channels continuously valid and out_ready=1, grants follow 0,1,...,N-1,0,... Each channel waits at most N-1 grants.
- Inputs: in_valid may drop without being granted; no stickiness is required of producers.
- Single requester: a single valid channel is granted every free cycle regardless of pointer position.
- Width rule: out_data is an exact W-bit copy of the selected word; no arithmetic is performed.

Test Plan:
- Reset then idle: rst pulse mid-cycle → out_valid=0, out_data=0, out_chan=0, in_ready=0000. Drive in_valid=0000 for 5 cycles → all outputs unchanged.
- Round-robin sweep (N=4, W=4, MODE 0): in_valid=1111, in_data ch0..3=3,5,9,C, out_ready=1 → out_chan sequence 0,1,2,3,0 on consecutive cycles; out_data 3,5,9,C,3; out_valid stays 1.
- Backpressure: one word loaded (ch2, data 9), then out_ready=0 for 3 cycles with in_valid=1111 → out_data=9 and out_chan=2 held; in_ready=0000. Release → next grant is ch3.
- Fixed priority (MODE 1): in_valid=1110, out_ready=1 → ch1 granted every cycle. Drop in_valid[1] → ch2 granted next.
- Wrap and sparse requests (MODE 0): last=3, in_valid=0100 → ch2 granted. Then in_valid=0101 → ch0 granted (scan 3→0 wraps), then ch2.
- Reset mid-operation: out_valid=1 holding ch1/data 5 under stall, assert rst → out_valid=0 immediately (async). After release with in_valid=1111 → ch0 granted first.
